// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types and defaults for the ALU command sequencer.
// It holds the ALU opcode enum, the sequencer state enum and the default register index width.
package alu_seq_pkg;
    localparam int DEF_REG_IDX_W = 3;
    typedef enum logic [1:0] {ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_AND = 2'b10, ALU_NOT = 2'b11} alu_op_t;
    typedef enum logic [2:0] {S_IDLE, S_LOAD_A, S_LOAD_B, S_EXEC, S_WRITE} seq_state_t;
endpackage

// File: rtl/alu_seq_decode.sv
// alu_seq_decode: Moore output decode of the sequencer state and the captured command fields.
// Inputs:  state_i, op_i, rd_i, rn_i, rm_i, wb_i (write-back enable for the captured command).
// Outputs: cmd_ready_o, readnum_o, loada_o, loadb_o, aluop_o, loadc_o, loads_o, writenum_o, write_o, done_o.
module alu_seq_decode
    import alu_seq_pkg::*;
#(
    parameter int REG_IDX_W = DEF_REG_IDX_W
) (
    input  seq_state_t           state_i,
    input  alu_op_t              op_i,
    input  logic [REG_IDX_W-1:0] rd_i,
    input  logic [REG_IDX_W-1:0] rn_i,
    input  logic [REG_IDX_W-1:0] rm_i,
    input  logic                 wb_i,
    output logic                 cmd_ready_o,
    output logic [REG_IDX_W-1:0] readnum_o,
    output logic                 loada_o,
    output logic                 loadb_o,
    output logic [1:0]           aluop_o,
    output logic                 loadc_o,
    output logic                 loads_o,
    output logic [REG_IDX_W-1:0] writenum_o,
    output logic                 write_o,
    output logic                 done_o
);
    always_comb begin
        cmd_ready_o = state_i == S_IDLE;
        loada_o     = state_i == S_LOAD_A;
        loadb_o     = state_i == S_LOAD_B;
        loadc_o     = state_i == S_EXEC;
        loads_o     = state_i == S_EXEC;
        done_o      = state_i == S_WRITE;
        write_o     = state_i == S_WRITE && wb_i;
        readnum_o   = loada_o ? rn_i : loadb_o ? rm_i : '0;
        aluop_o     = loadc_o ? op_i : ALU_ADD;
        writenum_o  = done_o ? rd_i : '0;
    end
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: runs one ALU command at a time through read A, read B, execute, write back.
// Ports: clk, reset_n (async, active low); command side cmd_valid/cmd_ready with cmd_op, cmd_rd,
// cmd_rn, cmd_rm (and cmd_nowb when ALU_SEQ_CMP_EN is defined); datapath side readnum, loada,
// loadb, ALUop, loadc, loads, writenum, write; status done pulse and ops_cnt completed count.
// Build option ALU_SEQ_CMP_EN: adds cmd_nowb, a compare-only command that suppresses write.
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int REG_IDX_W = DEF_REG_IDX_W,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [REG_IDX_W-1:0] cmd_rd,
    input  logic [REG_IDX_W-1:0] cmd_rn,
    input  logic [REG_IDX_W-1:0] cmd_rm,
`ifdef ALU_SEQ_CMP_EN
    input  logic                 cmd_nowb,
`endif
    output logic [REG_IDX_W-1:0] readnum,
    output logic                 loada,
    output logic                 loadb,
    output logic [1:0]           ALUop,
    output logic                 loadc,
    output logic                 loads,
    output logic [REG_IDX_W-1:0] writenum,
    output logic                 write,
    output logic                 done,
    output logic [CNT_W-1:0]     ops_cnt
);
    seq_state_t           state_q, state_d;
    alu_op_t              op_q;
    logic [REG_IDX_W-1:0] rd_q, rn_q, rm_q;
    logic [CNT_W-1:0]     cnt_q;
    logic                 wb;
    logic                 accept;

    assign accept = cmd_valid && cmd_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   state_d = !cmd_valid ? S_IDLE : alu_op_t'(cmd_op) == ALU_NOT ? S_LOAD_B : S_LOAD_A;
            S_LOAD_A: state_d = S_LOAD_B;
            S_LOAD_B: state_d = S_EXEC;
            S_EXEC:   state_d = S_WRITE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            op_q    <= ALU_ADD;
            rd_q    <= '0;
            rn_q    <= '0;
            rm_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_q + CNT_W'(done);
            if (accept) begin
                op_q <= alu_op_t'(cmd_op);
                rd_q <= cmd_rd;
                rn_q <= cmd_rn;
                rm_q <= cmd_rm;
            end
        end
    end

`ifdef ALU_SEQ_CMP_EN
    logic nowb_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) nowb_q <= 1'b0;
        else if (accept) nowb_q <= cmd_nowb;
    end
    assign wb = !nowb_q;
`else
    assign wb = 1'b1;
`endif

    assign ops_cnt = cnt_q;

    alu_seq_decode #(.REG_IDX_W(REG_IDX_W)) u_dec (
        .state_i     (state_q),
        .op_i        (op_q),
        .rd_i        (rd_q),
        .rn_i        (rn_q),
        .rm_i        (rm_q),
        .wb_i        (wb),
        .cmd_ready_o (cmd_ready),
        .readnum_o   (readnum),
        .loada_o     (loada),
        .loadb_o     (loadb),
        .aluop_o     (ALUop),
        .loadc_o     (loadc),
        .loads_o     (loads),
        .writenum_o  (writenum),
        .write_o     (write),
        .done_o      (done)
    );
endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed and random commands checked against a per-command step-list model.
module tb_alu_op_sequencer;
    localparam int W  = 3;
    localparam int CW = 8;
    localparam logic [14:0] IDLE_V = 15'h4000;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic [1:0]    cmd_op = '0;
    logic [W-1:0]  cmd_rd = '0, cmd_rn = '0, cmd_rm = '0;
    logic          cmd_nowb = 1'b0;
    logic          cmd_ready, loada, loadb, loadc, loads, write, done;
    logic [W-1:0]  readnum, writenum;
    logic [1:0]    ALUop;
    logic [CW-1:0] ops_cnt;

    int n_vec = 0;
    int n_err = 0;
    int cnt_m = 0;
    logic [14:0] exp_q[$];

    always #5 clk = ~clk;

    alu_op_sequencer #(.REG_IDX_W(W), .CNT_W(CW)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_rd    (cmd_rd),
        .cmd_rn    (cmd_rn),
        .cmd_rm    (cmd_rm),
`ifdef ALU_SEQ_CMP_EN
        .cmd_nowb  (cmd_nowb),
`endif
        .readnum   (readnum),
        .loada     (loada),
        .loadb     (loadb),
        .ALUop     (ALUop),
        .loadc     (loadc),
        .loads     (loads),
        .writenum  (writenum),
        .write     (write),
        .done      (done),
        .ops_cnt   (ops_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [14:0] mk(input logic rdy, input logic [W-1:0] rnum, input logic la, input logic lb,
                                       input logic [1:0] aop, input logic lcs, input logic [W-1:0] wnum,
                                       input logic wr, input logic dn);
        return {rdy, rnum, la, lb, aop, lcs, lcs, wnum, wr, dn};
    endfunction

    function automatic logic [14:0] dut_v();
        return {cmd_ready, readnum, loada, loadb, ALUop, loadc, loads, writenum, write, done};
    endfunction

    task automatic push_cmd(input logic [1:0] op, input logic [W-1:0] rd, input logic [W-1:0] rn,
                            input logic [W-1:0] rm, input logic nb);
        logic wb;
`ifdef ALU_SEQ_CMP_EN
        wb = !nb;
`else
        wb = 1'b1 | nb;
`endif
        if (op != 2'b11) exp_q.push_back(mk(1'b0, rn, 1'b1, 1'b0, 2'b00, 1'b0, '0, 1'b0, 1'b0));
        exp_q.push_back(mk(1'b0, rm, 1'b0, 1'b1, 2'b00, 1'b0, '0, 1'b0, 1'b0));
        exp_q.push_back(mk(1'b0, '0, 1'b0, 1'b0, op, 1'b1, '0, 1'b0, 1'b0));
        exp_q.push_back(mk(1'b0, '0, 1'b0, 1'b0, 2'b00, 1'b0, rd, wb, 1'b1));
    endtask

    task automatic step(input logic v, input logic [1:0] op, input logic [W-1:0] rd, input logic [W-1:0] rn,
                        input logic [W-1:0] rm, input logic nb);
        @(negedge clk);
        chk("outs", 32'(dut_v()), 32'(exp_q.size() != 0 ? exp_q[0] : IDLE_V));
        chk("ops_cnt", 32'(ops_cnt), 32'(cnt_m));
        cmd_valid = v;
        cmd_op    = op;
        cmd_rd    = rd;
        cmd_rn    = rn;
        cmd_rm    = rm;
        cmd_nowb  = nb;
        if (exp_q.size() != 0) begin
            if (exp_q[0][0]) cnt_m = (cnt_m + 1) % (1 << CW);
            void'(exp_q.pop_front());
        end else if (v) begin
            push_cmd(op, rd, rn, rm, nb);
        end
    endtask

    task automatic rnd_step(input int pct);
        step($urandom_range(0, 99) < pct, 2'($urandom), W'($urandom), W'($urandom), W'($urandom), 1'($urandom));
    endtask

    initial begin
        int guard;
        #12;
        chk("reset_outs", 32'(dut_v()), 32'(IDLE_V));
        chk("reset_cnt", 32'(ops_cnt), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        step(1'b1, 2'b00, 3'd2, 3'd0, 3'd1, 1'b0);
        step(1'b0, 2'b00, 3'd0, 3'd0, 3'd0, 1'b0);
        repeat (4) step(1'b0, 2'b00, 3'd0, 3'd0, 3'd0, 1'b0);
        step(1'b1, 2'b11, 3'd5, 3'd7, 3'd3, 1'b0);
        repeat (4) step(1'b0, 2'b00, 3'd0, 3'd0, 3'd0, 1'b0);
        step(1'b1, 2'b01, 3'd6, 3'd4, 3'd5, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 2'(i), W'(i + 1), W'(i + 2), W'(i + 3), 1'b0);
        repeat (5) step(1'b0, 2'b00, 3'd0, 3'd0, 3'd0, 1'b0);
        step(1'b1, 2'b01, 3'd4, 3'd1, 3'd2, 1'b1);
        repeat (5) step(1'b0, 2'b00, 3'd0, 3'd0, 3'd0, 1'b0);
        step(1'b1, 2'b00, 3'd6, 3'd1, 3'd2, 1'b0);
        step(1'b0, 2'b00, 3'd0, 3'd0, 3'd0, 1'b0);
        step(1'b0, 2'b00, 3'd0, 3'd0, 3'd0, 1'b0);
        @(posedge clk);
        #2;
        chk("pre_reset_exec", 32'(loadc), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("abort_outs", 32'(dut_v()), 32'(IDLE_V));
        chk("abort_cnt", 32'(ops_cnt), 32'd0);
        exp_q.delete();
        cnt_m = 0;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (600) rnd_step(60);
        guard = 0;
        while (cnt_m != (1 << CW) - 1 && guard < 3000) begin
            rnd_step(90);
            guard++;
        end
        chk("wrap_reach", 32'(cnt_m), 32'((1 << CW) - 1));
        step(1'b1, 2'b10, 3'd1, 3'd2, 3'd3, 1'b0);
        repeat (6) step(1'b0, 2'b00, 3'd0, 3'd0, 3'd0, 1'b0);
        @(negedge clk);
        chk("wrap_zero", 32'(ops_cnt), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
